// File: rtl/core_boot_pkg.sv
// rtl/core_boot_pkg.sv - shared types and constants for the boot/run sequencer
package core_boot_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_LOAD,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } boot_state_e;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         HDR_BYTES      = 2;
    localparam int         BYTES_PER_WORD = 4;

endpackage

// File: rtl/core_boot_ctrl_byte_packer.sv
// rtl/core_boot_ctrl_byte_packer.sv - packs 4 bytes little-endian into a 32-bit word
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   clear             drop any partial word (pulsed on load entry)
//   byte_valid/data   incoming byte strobe and value
//   word_valid        1-cycle strobe, the cycle after the 4th byte
//   word              assembled word, first byte in [7:0]
module byte_packer
    import core_boot_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        word_valid,
    output logic [31:0] word
);

    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_WORD - 1);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] word_q, word_d;
    logic        word_valid_q, word_valid_d;

    always_comb begin
        cnt_d        = cnt_q;
        word_d       = word_q;
        word_valid_d = 1'b0;
        if (clear) begin
            cnt_d  = 2'd0;
            word_d = 32'd0;
        end else if (byte_valid) begin
            // Shift right so the first byte ends up in the low lane.
            word_d       = {byte_data, word_q[31:8]};
            cnt_d        = cnt_q + 2'd1;
            word_valid_d = (cnt_q == LAST_BYTE);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q        <= 2'd0;
            word_q       <= 32'd0;
            word_valid_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
        end
    end

    assign word_valid = word_valid_q;
    assign word       = word_q;

endmodule

// File: rtl/core_boot_ctrl.sv
// rtl/core_boot_ctrl.sv - boot loader and run/halt sequencer for the single-cycle core
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rx_valid, rx_data     UART byte stream
//   imem_we/addr/wdata    instruction memory write port
//   core_rst_n, core_en   core reset (active low) and clock enable
//   core_pc               core next-pc, watched for the halt condition
//   last_pc               word count minus 1 (halt address)
//   done, error           status levels
//   cycle_count           cycles spent in RUN, frozen afterwards
module core_boot_ctrl
    import core_boot_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = 10,
    parameter int TMO_W      = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic [31:0]       core_pc,
    output logic [31:0]       last_pc,
    output logic              done,
    output logic              error,
    output logic [TMO_W-1:0]  cycle_count
);

    localparam logic [0:0] HDR_LAST = 1'(HDR_BYTES - 1);

    boot_state_e       state_q, state_d;
    logic [7:0]        hdr_lo_q, hdr_lo_d;
    logic [0:0]        hdr_cnt_q, hdr_cnt_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [31:0]       last_pc_q, last_pc_d;
    logic [TMO_W-1:0]  cycle_q, cycle_d;
    logic              pc_match_q, pc_match_d;

    logic        rx_sync;
    logic [15:0] hdr_n;
    logic        word_valid;
    logic [31:0] word;
    logic        packer_clear;
    logic        imem_we_c;

    assign rx_sync = rx_valid && (rx_data == SYNC_BYTE);
    assign hdr_n   = {rx_data, hdr_lo_q};

    always_comb begin
        state_d    = state_q;
        hdr_lo_d   = hdr_lo_q;
        hdr_cnt_d  = hdr_cnt_q;
        index_d    = index_q;
        last_pc_d  = last_pc_q;
        cycle_d    = cycle_q;
        pc_match_d = 1'b0;
        imem_we_c  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (rx_sync) begin
                    state_d   = ST_HDR;
                    hdr_cnt_d = 1'b0;
                    cycle_d   = '0;
                end
            end
            ST_HDR: begin
                if (rx_valid) begin
                    if (hdr_cnt_q != HDR_LAST) begin
                        hdr_lo_d  = rx_data;
                        hdr_cnt_d = hdr_cnt_q + 1'b1;
                    end else begin
                        hdr_cnt_d = 1'b0;
                        if (hdr_n == 16'd0 || {16'd0, hdr_n} > 32'(IMEM_DEPTH)) begin
                            state_d = ST_ERR;
                        end else begin
                            state_d   = ST_LOAD;
                            last_pc_d = {16'd0, hdr_n} - 32'd1;
                            index_d   = '0;
                        end
                    end
                end
            end
            ST_LOAD: begin
                if (word_valid) begin
                    imem_we_c = 1'b1;
                    // Index stops at the last word so the address stays in range.
                    if ({{(32-ADDR_W){1'b0}}, index_q} == last_pc_q) begin
                        state_d = ST_RUN;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end
            end
            ST_RUN: begin
                cycle_d    = cycle_q + 1'b1;
                pc_match_d = (core_pc == last_pc_q);
                // Halt is checked first so it wins over a coincident timeout.
                if (pc_match_d && pc_match_q) begin
                    state_d = ST_DONE;
                end else if (cycle_d == '1) begin
                    state_d = ST_ERR;
                end
            end
            ST_DONE, ST_ERR: begin
                if (rx_sync) begin
                    state_d   = ST_HDR;
                    hdr_cnt_d = 1'b0;
                    cycle_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            hdr_lo_q   <= 8'd0;
            hdr_cnt_q  <= 1'b0;
            index_q    <= '0;
            last_pc_q  <= 32'd0;
            cycle_q    <= '0;
            pc_match_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            hdr_lo_q   <= hdr_lo_d;
            hdr_cnt_q  <= hdr_cnt_d;
            index_q    <= index_d;
            last_pc_q  <= last_pc_d;
            cycle_q    <= cycle_d;
            pc_match_q <= pc_match_d;
        end
    end

    assign packer_clear = (state_d == ST_LOAD) && (state_q != ST_LOAD);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (packer_clear),
        .byte_valid (rx_valid && (state_q == ST_LOAD)),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    assign imem_we     = imem_we_c;
    assign imem_addr   = index_q;
    assign imem_wdata  = word;
    assign core_rst_n  = (state_q == ST_RUN) || (state_q == ST_DONE);
    assign core_en     = (state_q == ST_RUN);
    assign last_pc     = last_pc_q;
    assign done        = (state_q == ST_DONE);
    assign error       = (state_q == ST_ERR);
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// tb/tb_core_boot_ctrl.sv - scoreboard testbench for core_boot_ctrl
module tb_core_boot_ctrl;

    localparam int IMEM_DEPTH = 1024;
    localparam int ADDR_W     = 10;
    localparam int TMO_W      = 4;
    localparam int TMO_LIMIT  = (1 << TMO_W) - 1;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              rx_valid;
    logic [7:0]        rx_data;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              core_rst_n;
    logic              core_en;
    logic [31:0]       core_pc;
    logic [31:0]       last_pc;
    logic              done;
    logic              error;
    logic [TMO_W-1:0]  cycle_count;

    always #5 clk = ~clk;

    core_boot_ctrl #(
        .IMEM_DEPTH (IMEM_DEPTH),
        .ADDR_W     (ADDR_W),
        .TMO_W      (TMO_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .imem_we     (imem_we),
        .imem_addr   (imem_addr),
        .imem_wdata  (imem_wdata),
        .core_rst_n  (core_rst_n),
        .core_en     (core_en),
        .core_pc     (core_pc),
        .last_pc     (last_pc),
        .done        (done),
        .error       (error),
        .cycle_count (cycle_count)
    );

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    typedef struct {
        bit          is_done;
        int          count;
        logic [31:0] lpc;
    } end_t;

    wr_t  wr_q[$];
    end_t end_q[$];
    wr_t  mw;
    end_t me;

    int          total = 0;
    int          bad   = 0;
    int          park_at = 1000;
    int          run_k   = 0;
    logic [31:0] cur_lpc = 32'd0;
    bit          done_prev = 1'b0;
    bit          err_prev  = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Core model: in RUN cycle k (1-based) the pc sits at the halt address once k >= park_at.
    always @(negedge clk) begin
        if (core_en) begin
            run_k++;
            if (run_k >= park_at) core_pc = cur_lpc;
            else                  core_pc = cur_lpc + 32'd1 + 32'($urandom_range(0, 50));
        end else begin
            run_k   = 0;
            core_pc = 32'd0;
        end
    end

    // Monitor: pops expected writes and end-of-run outcomes as the DUT presents them.
    always @(negedge clk) begin
        if (rst_n && imem_we) begin
            if (wr_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_write: got addr %0h data %0h want none", imem_addr, imem_wdata);
            end else begin
                mw = wr_q.pop_front();
                chk("imem_addr", 64'(imem_addr), 64'(mw.addr));
                chk("imem_wdata", 64'(imem_wdata), 64'(mw.data));
            end
        end
        if (rst_n && ((done && !done_prev) || (error && !err_prev))) begin
            if (end_q.size() == 0) begin
                total++; bad++;
                $display("FAIL unexpected_end: got done %0b error %0b want none", done, error);
            end else begin
                me = end_q.pop_front();
                chk("end_done", 64'(done), 64'(me.is_done));
                chk("end_error", 64'(error), 64'(!me.is_done));
                chk("end_cycle_count", 64'(cycle_count), 64'(me.count));
                chk("end_core_en", 64'(core_en), 64'd0);
                chk("end_core_rst_n", 64'(core_rst_n), 64'(me.is_done));
                if (me.is_done) chk("end_last_pc", 64'(last_pc), 64'(me.lpc));
            end
        end
        done_prev = done;
        err_prev  = error;
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_data  = b;
        @(negedge clk);
        rx_valid = 1'b0;
        rx_data  = $urandom();
        repeat (gap) @(negedge clk);
    endtask

    task automatic send_word(input logic [31:0] w, input int addr, input int maxgap);
        wr_q.push_back('{addr: ADDR_W'(addr), data: w});
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], $urandom_range(0, maxgap));
    endtask

    task automatic wait_end();
        int c = 0;
        while (!(done || error) && c < 400) begin
            @(negedge clk);
            c++;
        end
        total++;
        if (c >= 400) begin
            bad++;
            $display("FAIL wait_end: got no done/error after %0d cycles want done or error", c);
        end
        @(negedge clk);
    endtask

    // Expected outcome from the halt/timeout rules: halt on RUN cycle park+1 unless the
    // count has already reached all-ones on an earlier cycle.
    task automatic run_prog(input int n, input int p, input bit junk, input bit sync, input int maxgap);
        int c;
        cur_lpc = 32'(n - 1);
        park_at = p;
        if (p + 1 <= TMO_LIMIT) end_q.push_back('{is_done: 1'b1, count: p + 1, lpc: 32'(n - 1)});
        else                    end_q.push_back('{is_done: 1'b0, count: TMO_LIMIT, lpc: 32'(n - 1)});
        if (sync) send_byte(8'hA5, $urandom_range(0, 2));
        send_byte(8'(n), $urandom_range(0, 2));
        send_byte(8'(n >> 8), $urandom_range(0, 2));
        for (int i = 0; i < n; i++) send_word($urandom(), i, maxgap);
        if (junk) begin
            c = 0;
            while (!core_en && c < 20) begin
                @(negedge clk);
                c++;
            end
            send_byte(8'hA5, 0);
            send_byte(8'($urandom()), 0);
        end
        wait_end();
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("rst_core_en", 64'(core_en), 64'd0);
        chk("rst_last_pc", 64'(last_pc), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_cycle_count", 64'(cycle_count), 64'd0);
        chk("rst_imem_we", 64'(imem_we), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish want finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rx_data = 8'd0;
        core_pc = 32'd0;
        do_reset();

        // Directed stream: two words, park at pc 1 from RUN cycle 5.
        cur_lpc = 32'd1;
        park_at = 5;
        wr_q.push_back('{addr: ADDR_W'(0), data: 32'h0000_0013});
        wr_q.push_back('{addr: ADDR_W'(1), data: 32'h0010_0093});
        end_q.push_back('{is_done: 1'b1, count: 6, lpc: 32'd1});
        send_byte(8'hA5, 0); send_byte(8'h02, 1); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h00, 2); send_byte(8'h00, 0); send_byte(8'h00, 0);
        send_byte(8'h93, 1); send_byte(8'h00, 0); send_byte(8'h10, 0); send_byte(8'h00, 0);
        wait_end();

        // SYNC in DONE restarts into the header phase.
        send_byte(8'hA5, 0);
        chk("restart_done", 64'(done), 64'd0);
        chk("restart_core_rst_n", 64'(core_rst_n), 64'd0);
        chk("restart_cycle_count", 64'(cycle_count), 64'd0);
        run_prog(3, 7, 1'b1, 1'b0, 2);

        // Bad headers: N=0 and N=1025.
        end_q.push_back('{is_done: 1'b0, count: 0, lpc: 32'd0});
        send_byte(8'hA5, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        wait_end();
        end_q.push_back('{is_done: 1'b0, count: 0, lpc: 32'd0});
        send_byte(8'hA5, 0); send_byte(8'h01, 0); send_byte(8'h04, 0);
        wait_end();

        // Timeout boundaries.
        run_prog(1, 100, 1'b1, 1'b1, 1);
        run_prog(1, 14, 1'b0, 1'b1, 1);
        run_prog(2, 15, 1'b0, 1'b1, 1);
        run_prog(1, 13, 1'b0, 1'b1, 1);

        // Largest legal program fills imem up to the last address.
        run_prog(IMEM_DEPTH, 2, 1'b0, 1'b1, 0);

        // Reset part-way through word 1, then noise and a fresh load.
        cur_lpc = 32'd1;
        park_at = 1000;
        send_byte(8'hA5, 0); send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'hDEAD_BEEF, 0, 1);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        do_reset();
        send_byte(8'h00, 1);
        send_byte(8'hFF, 0);
        run_prog(2, 3, 1'b0, 1'b1, 2);

        for (int it = 0; it < 8; it++) begin
            int n = $urandom_range(1, 6);
            int p = $urandom_range(1, 18);
            run_prog(n, p, (p >= 6), 1'b1, 2);
        end

        repeat (3) @(negedge clk);
        chk("wr_q_empty", 64'(wr_q.size()), 64'd0);
        chk("end_q_empty", 64'(end_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
